// File: rtl/debounce_oneshot.sv
// Push-button debouncer with a 2-flop synchronizer; emits a one-cycle D_out pulse per accepted press.
// Define DEBOUNCE_AUTOREPEAT_EN to add a periodic repeat pulse while the button stays held.
module debounce_oneshot #(
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned REPEAT_CYCLES = 25000000,
    parameter int unsigned CNT_W         = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic D_out,
    output logic btn_level
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

    // Out-of-range values would let the counters wrap, so reject them at elaboration.
    if (STABLE_CYCLES < 32'd1 || 64'(STABLE_CYCLES) >= (64'd1 << CNT_W) ||
        REPEAT_CYCLES < 32'd1 || 64'(REPEAT_CYCLES) >= (64'd1 << CNT_W)) begin : g_param_err
        $error("debounce_oneshot: STABLE_CYCLES/REPEAT_CYCLES out of range for CNT_W");
    end

    logic           sync1_r;
    logic           sync2_r;
    state_t         state_r;
    logic [CNT_W-1:0] cnt_r;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_CYCLES);
    logic [CNT_W-1:0] rep_r;
`endif

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
        end
    end

    // Debounce FSM with stability counter; D_out and btn_level are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE_LOW;
            cnt_r     <= CNT_ZERO;
            D_out     <= 1'b0;
            btn_level <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rep_r     <= CNT_ZERO;
`endif
        end else begin
            D_out <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rep_r <= CNT_ZERO;
`endif
            case (state_r)
                IDLE_LOW: begin
                    btn_level <= 1'b0;
                    if (sync2_r) begin
                        state_r <= WAIT_HIGH;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2_r) begin
                        state_r   <= IDLE_LOW;
                        cnt_r     <= CNT_ZERO;
                        btn_level <= 1'b0;
                    end else if (cnt_r == STABLE_C) begin
                        state_r   <= HIGH;
                        cnt_r     <= CNT_ZERO;
                        D_out     <= 1'b1;
                        btn_level <= 1'b1;
                    end else begin
                        cnt_r     <= cnt_r + CNT_ONE;
                        btn_level <= 1'b0;
                    end
                end
                HIGH: begin
                    btn_level <= 1'b1;
                    if (!sync2_r) begin
                        state_r <= WAIT_LOW;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= CNT_ZERO;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                        if (rep_r == REPEAT_C) begin
                            rep_r <= CNT_ZERO;
                            D_out <= 1'b1;
                        end else begin
                            rep_r <= rep_r + CNT_ONE;
                        end
`endif
                    end
                end
                WAIT_LOW: begin
                    if (sync2_r) begin
                        // Release glitch: back to HIGH without a new pulse.
                        state_r   <= HIGH;
                        cnt_r     <= CNT_ZERO;
                        btn_level <= 1'b1;
                    end else if (cnt_r == STABLE_C) begin
                        state_r   <= IDLE_LOW;
                        cnt_r     <= CNT_ZERO;
                        btn_level <= 1'b0;
                    end else begin
                        cnt_r     <= cnt_r + CNT_ONE;
                        btn_level <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE_LOW;
                    cnt_r     <= CNT_ZERO;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/debounce_oneshot.md
# debounce_oneshot

Debounces one raw mechanical push-button input and emits a single-clock-cycle `D_out` pulse per confirmed press. It is the producer side of the `D_out` increment-enable interface: `D_out` drives the enable of the 32-bit event counter directly, so each physical press advances the count by exactly 1. It also exports the debounced button level for LEDs and status logic.

## Interface
- `STABLE_CYCLES`, default 500000: consecutive identical synchronized samples required to accept a level change. Legal range 1 .. 2^CNT_W-1.
- `REPEAT_CYCLES`, default 25000000: auto-repeat period. Used only when `DEBOUNCE_AUTOREPEAT_EN` is defined. Legal range 1 .. 2^CNT_W-1.
- `CNT_W`, default 25: width of the internal counters.
- `clk`, input, 1: the only clock. All state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `btn_in`, input, 1: raw asynchronous button level, 1 = pressed.
- `D_out`, output, 1: registered one-cycle pulse per accepted press (and per repeat, if enabled).
- `btn_level`, output, 1: registered debounced level, 1 = pressed.

## Operation
- **Synchronizer:** 2-flop chain `sync1` → `sync2`. The FSM sees only `sync2`.
- **States:** `IDLE_LOW`, `WAIT_HIGH`, `HIGH`, `WAIT_LOW`. Stability counter `cnt` is CNT_W bits.
- **`IDLE_LOW`:** if `sync2`=1, go to `WAIT_HIGH` with `cnt`=1. Otherwise stay, with `cnt`=0.
- **`WAIT_HIGH`:**
  - `sync2`=0: go to `IDLE_LOW`, `cnt`=0. No pulse.
  - `sync2`=1 and `cnt`==STABLE_CYCLES: go to `HIGH`, `cnt`=0.
  - Otherwise: `cnt`+1.
- **`HIGH`:** if `sync2`=0, go to `WAIT_LOW` with `cnt`=1. Otherwise stay.
- **`WAIT_LOW`:**
  - `sync2`=1: return to `HIGH`, `cnt`=0. No new pulse.
  - `sync2`=0 and `cnt`==STABLE_CYCLES: go to `IDLE_LOW`.
  - Otherwise: `cnt`+1.
- **`D_out`:** 1 for exactly the one cycle following the `WAIT_HIGH`→`HIGH` transition. Otherwise 0, except for repeats (see Configuration).
- **`btn_level`:** 1 in `HIGH` and `WAIT_LOW`, 0 in `IDLE_LOW` and `WAIT_HIGH`. Updated on the same edge as the state register.
- **Release:** never produces a pulse.
- **Glitches:** a glitch shorter than STABLE_CYCLES samples in either `WAIT_*` state aborts the transition with no output change.
- **Counter bound:** `cnt` never exceeds STABLE_CYCLES, so no wrap is possible for legal parameters.

## Timing
- **Reset values** (next edge with `rst`=1): `sync1`=`sync2`=0, state=`IDLE_LOW`, `cnt`=0, repeat counter=0, `D_out`=0, `btn_level`=0.
- **`rst` has priority** over all other activity on that edge.
- **Reset mid-operation:** an in-flight press is discarded and no pulse is emitted. A button still held after reset deasserts is debounced anew: it yields one pulse after the full latency.
- **Press latency:** `btn_in` first sampled 1 at edge N, and stable thereafter, gives `D_out`=1 and `btn_level`=1 in the cycle after edge N+STABLE_CYCLES+2.
- **Release latency:** same as press; `btn_level` falls in the cycle after edge N+STABLE_CYCLES+2.
- **Pulse spacing:** minimum spacing between non-repeat pulses is 2·(STABLE_CYCLES+1) cycles.
- **Downstream view:** `D_out` is glitch-free and registered. The consumer counter increments on the edge that ends the pulse cycle.

## Configuration
- **Macro:** `DEBOUNCE_AUTOREPEAT_EN`.
- **Defined:** a CNT_W-bit repeat counter runs in `HIGH`.
  - It clears on entry to `HIGH` and on any exit from `HIGH`.
  - It increments each cycle while in `HIGH`.
  - When it reaches REPEAT_CYCLES it reloads to 0 and `D_out` pulses for one cycle.
  - So a held button yields one pulse at press, then one every REPEAT_CYCLES+1 cycles.
  - Time spent in `WAIT_LOW` pauses the counter; returning to `HIGH` restarts it from 0.
- **Undefined:** the repeat counter is not built and REPEAT_CYCLES is ignored. Exactly one pulse per press.

## Test plan
Use STABLE_CYCLES=4 and REPEAT_CYCLES=8 unless noted.
- **Reset:** hold `rst`=1 for 3 cycles with `btn_in`=1 → `D_out`=0 and `btn_level`=0 throughout. After release, a single `D_out` pulse appears 6 edges after the first post-reset sample.
- **Clean press:** `btn_in` 0→1 held 20 cycles, then 0 → exactly one `D_out` pulse, 6 edges after the rising sample. `btn_level` high from that cycle until 6 edges after the release sample. A downstream 32-bit counter reads 1.
- **Bounce:** `btn_in` toggles 1,0,1,1,0,1 at 1-cycle intervals, then stays 1 → no pulse during the bounce. Exactly one pulse 6 edges after the final stable rise.
- **Release bounce:** in `HIGH`, `btn_in` drops to 0 for 3 cycles, then returns to 1 → `btn_level` stays 1 and no second pulse.
- **Reset mid-press:** assert `rst` while in `WAIT_HIGH` with `cnt`=3 → no pulse. After reset, with the button still held, one pulse arrives 6 edges after the first post-reset sample.
- **Auto-repeat (`DEBOUNCE_AUTOREPEAT_EN` defined):** hold `btn_in`=1 for 40 cycles → pulses at press+0, +9, +18 and +27 cycles. With the macro undefined → a single pulse.
